hangman_round_ctrl: RTL and testbench
=====================================

# hangman_round_ctrl

Parametrised round controller for the two-player hangman game. Player 1 enters a secret word one character at a time. Player 2 then guesses characters against it. The block tracks revealed positions, misses (the hangman part count), repeated guesses and a per-guess timeout, and keeps both players' scores across rounds. It sits between the keyboard/switch input decoder and the VGA drawing FSM, which reads `reveal_mask`, `misses` and `state` to render dashes, letters and body parts.

## Interface
- `MAX_LEN`, default 8: maximum word length in characters.
- `CHAR_W`, default 5: character code width. Code 0 is reserved as "no character".
- `MAX_MISSES`, default 9: misses that complete the hangman and lose the round.
- `TIME_LIMIT`, default 30: `tick` pulses allowed per guess.
- `SCORE_W`, default 7: score counter width.
- `clk`, in, 1: the single clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a new round. Only honoured in IDLE or DONE.
- `char_in`, in, CHAR_W: character code, sampled when `char_valid` is high.
- `char_valid`, in, 1: one-cycle strobe for a character entry or a guess.
- `word_done`, in, 1: ends word entry.
- `tick`, in, 1: timebase strobe, one cycle wide.
- `state`, out, 3: current FSM state, encoded as in the package.
- `word_out`, out, MAX_LEN*CHAR_W: stored word. Character i occupies bits [i*CHAR_W +: CHAR_W].
- `word_len`, out, $clog2(MAX_LEN+1): number of characters stored.
- `reveal_mask`, out, MAX_LEN: bit i is 1 when character i has been guessed.
- `misses`, out, $clog2(MAX_MISSES+1): miss count.
- `time_left`, out, $clog2(TIME_LIMIT+1): ticks remaining for the current guess.
- `hit`, `miss`, `repeat_guess`, out, 1 each: one-cycle result pulses.
- `round_over`, out, 1: high in DONE.
- `p2_won`, out, 1: result of the last round. Valid while `round_over` is high.
- `p1_score`, `p2_score`, out, SCORE_W: scores. Both saturate at all-ones.

## Operation
- States: IDLE, LOAD, GUESS, CHECK, WIN, LOSE, DONE.
- Reset drives all outputs to 0 and the state to IDLE.
- `start` in IDLE or DONE moves the FSM to LOAD. On that transition `word_out`, `word_len`, `reveal_mask`, `misses`, `p2_won` and the guessed-set bitmap clear. Scores are untouched. `start` in any other state is ignored.
- LOAD:
  - `char_valid` with a nonzero code, while `word_len < MAX_LEN`, writes the code at index `word_len` and increments `word_len`.
  - Code 0, or a full word, is ignored.
  - `word_done` with `word_len == 0` is ignored.
  - `word_done` with `word_len > 0` moves the FSM to GUESS and loads `time_left = TIME_LIMIT`.
  - If `char_valid` and `word_done` arrive together, the character is stored first, then the transition is taken.
- GUESS:
  - `char_valid` with a nonzero code latches the guess and moves the FSM to CHECK. Code 0 is ignored.
  - `tick` decrements `time_left`. If `time_left` reaches 0 on that tick, the FSM moves to LOSE.
  - If `char_valid` and `tick` arrive in the same cycle, the guess takes priority and the tick is dropped.
- CHECK lasts one cycle and takes exactly one of three branches:
  - Guess already in the guessed set: pulse `repeat_guess`. No miss, no timer reload, return to GUESS.
  - Guess matches one or more positions within `word_len`: OR every matching position into `reveal_mask`, pulse `hit`, reload the timer.
  - Guess matches no position: increment `misses`, pulse `miss`, reload the timer.
  - For a hit or a miss, the guess is then added to the guessed set (2^CHAR_W bits).
  - Next state: WIN if every bit below `word_len` is revealed; else LOSE if `misses == MAX_MISSES`; else GUESS. WIN is checked first.
- WIN: `p2_score` +1 and `p2_won` = 1, then DONE.
- LOSE: `p1_score` +1 and `p2_won` = 0, then DONE.
- Each of WIN and LOSE lasts one cycle, so there is exactly one score increment per round.
- `reveal_mask` bits at or above `word_len` are always 0.

## Timing
- LOAD: a write is visible on `word_out`/`word_len` in the cycle after the `char_valid` strobe.
- Guess latency, with the strobe in cycle N:
  - cycle N+1: the FSM is in CHECK.
  - cycle N+2: the result pulse is high, `reveal_mask`/`misses` are updated, and the FSM is in GUESS, WIN or LOSE.
  - cycle N+3: the score is updated and `round_over` = 1.
- `char_valid` during CHECK, WIN, LOSE or DONE is dropped. No queueing.
- `tick` outside GUESS is ignored.
- Timeout: the tick that takes `time_left` from 1 to 0 is the last one. The FSM is in LOSE one cycle later.
- `resetn` deasserted mid-round aborts the round immediately. All state returns to reset values, including the scores.

## Structure
- Package `hangman_pkg` holds:
  - the state enum (3-bit encoding);
  - `CHAR_NONE` = 0;
  - default parameter constants.
- Sub-module `guess_timer`: a loadable down-counter with `load`, `en` (gated tick) and `expire` (a one-cycle pulse on reaching 0). It is parametrised by TIME_LIMIT.
- The position compare is a combinational generate loop over MAX_LEN, feeding a match vector.

## Test plan
- **Win:** load "CAB" (codes 3,1,2), `word_done`, guess 1, 2, 3. Expect `hit` ×3, `reveal_mask` = 3'b111, WIN, `p2_score` = 1, `round_over` = 1, `p2_won` = 1.
- **Lose:** load "A" (1), guess 9 distinct non-matching codes. Expect `misses` counting 1..9, LOSE, `p1_score` = 1, `p2_won` = 0.
- **Repeat guess:** word "AA" (1,1). Guess 5 → `miss`. Guess 5 again → `repeat_guess` only, `misses` stays 1. Guess 1 → `hit`, mask = 2'b11, WIN.
- **Timeout:** with TIME_LIMIT = 3, enter GUESS and send 3 ticks. Expect `time_left` 3→2→1→0, then LOSE and `p1_score` +1.
- **Timer reload and priority:** a guess arriving on the same cycle as the tick that would expire the timer is accepted, and `time_left` reloads to TIME_LIMIT.
- **Boundary cases:**
  - 9 characters entered with MAX_LEN = 8: `word_len` = 8, and the 9th character is ignored.
  - `word_done` at length 0 is ignored.
  - `resetn` low mid-GUESS: all outputs return to 0.
  - Scores at 127 stay at 127 after another win.

Source files
------------

// File: rtl/hangman_round_ctrl_pkg.sv
// Shared state encoding, reserved character code and default sizes
// for the hangman round controller.
package hangman_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GUESS = 3'd2,
        CHECK = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int CHAR_NONE = 0;

    localparam int DEF_MAX_LEN    = 8;
    localparam int DEF_CHAR_W     = 5;
    localparam int DEF_MAX_MISSES = 9;
    localparam int DEF_TIME_LIMIT = 30;
    localparam int DEF_SCORE_W    = 7;

endpackage

// File: rtl/hangman_round_ctrl_guess_timer.sv
// Per-guess countdown: reloads to TIME_LIMIT, counts down on gated ticks and
// flags the tick that empties it in the same cycle so the FSM can leave at once.
module guess_timer
    import hangman_pkg::*;
#(
    parameter int TIME_LIMIT = DEF_TIME_LIMIT
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            load,
    input  logic                            en,
    output logic [$clog2(TIME_LIMIT+1)-1:0] time_left,
    output logic                            expire
);

    localparam int TW = $clog2(TIME_LIMIT+1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            time_left <= '0;
        end else if (load) begin
            time_left <= TW'(TIME_LIMIT);
        end else if (en && time_left != '0) begin
            time_left <= time_left - 1'b1;
        end
    end

    assign expire = en && (time_left == TW'(1));

endmodule

// File: rtl/hangman_round_ctrl.sv
// Hangman round controller: word entry, guess checking, miss/timeout tracking
// and saturating per-player scores that survive from round to round.
module hangman_round_ctrl
    import hangman_pkg::*;
#(
    parameter int MAX_LEN    = DEF_MAX_LEN,
    parameter int CHAR_W     = DEF_CHAR_W,
    parameter int MAX_MISSES = DEF_MAX_MISSES,
    parameter int TIME_LIMIT = DEF_TIME_LIMIT,
    parameter int SCORE_W    = DEF_SCORE_W
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [CHAR_W-1:0]               char_in,
    input  logic                            char_valid,
    input  logic                            word_done,
    input  logic                            tick,
    output logic [2:0]                      state,
    output logic [MAX_LEN*CHAR_W-1:0]       word_out,
    output logic [$clog2(MAX_LEN+1)-1:0]    word_len,
    output logic [MAX_LEN-1:0]              reveal_mask,
    output logic [$clog2(MAX_MISSES+1)-1:0] misses,
    output logic [$clog2(TIME_LIMIT+1)-1:0] time_left,
    output logic                            hit,
    output logic                            miss,
    output logic                            repeat_guess,
    output logic                            round_over,
    output logic                            p2_won,
    output logic [SCORE_W-1:0]              p1_score,
    output logic [SCORE_W-1:0]              p2_score
);

    localparam int LEN_W  = $clog2(MAX_LEN+1);
    localparam int MISS_W = $clog2(MAX_MISSES+1);
    localparam int NCODES = 2**CHAR_W;

    state_t              cur, nxt;
    logic [CHAR_W-1:0]   guess_q;
    logic [NCODES-1:0]   guessed;
    logic [MAX_LEN-1:0]  match, len_mask, new_mask;
    logic [MISS_W-1:0]   new_misses;
    logic                char_ok, load_wr, load_end, guess_take;
    logic                tmr_load, tmr_en, tmr_expire, is_repeat, all_revealed;

    assign char_ok    = char_valid && (char_in != CHAR_W'(CHAR_NONE));
    assign load_wr    = (cur == LOAD) && char_ok && (word_len < LEN_W'(MAX_LEN));
    assign load_end   = (cur == LOAD) && word_done && ((word_len != '0) || load_wr);
    assign guess_take = (cur == GUESS) && char_ok;
    assign tmr_en     = (cur == GUESS) && tick && !char_ok;
    assign tmr_load   = load_end || ((cur == CHECK) && !is_repeat);
    assign is_repeat  = guessed[guess_q];

    genvar i;
    generate
        for (i = 0; i < MAX_LEN; i++) begin : g_cmp
            assign len_mask[i] = (LEN_W'(i) < word_len);
            assign match[i]    = len_mask[i] && (word_out[i*CHAR_W +: CHAR_W] == guess_q);
        end
    endgenerate

    // Masked positions beyond word_len never match, so stale bits cannot leak in.
    assign new_mask     = is_repeat ? reveal_mask : (reveal_mask | match);
    assign new_misses   = (is_repeat || match != '0) ? misses : misses + 1'b1;
    assign all_revealed = ((new_mask & len_mask) == len_mask);

    guess_timer #(.TIME_LIMIT(TIME_LIMIT)) u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .load      (tmr_load),
        .en        (tmr_en),
        .time_left (time_left),
        .expire    (tmr_expire)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cur <= IDLE;
        else         cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE, DONE: if (start) nxt = LOAD;
            LOAD:       if (load_end) nxt = GUESS;
            GUESS: begin
                if (guess_take)      nxt = CHECK;
                else if (tmr_expire) nxt = LOSE;
            end
            CHECK: begin
                if (all_revealed)                          nxt = WIN;
                else if (new_misses == MISS_W'(MAX_MISSES)) nxt = LOSE;
                else                                       nxt = GUESS;
            end
            WIN, LOSE:  nxt = DONE;
            default:    nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_out     <= '0;
            word_len     <= '0;
            reveal_mask  <= '0;
            misses       <= '0;
            guessed      <= '0;
            guess_q      <= '0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            repeat_guess <= 1'b0;
            p2_won       <= 1'b0;
            p1_score     <= '0;
            p2_score     <= '0;
        end else begin
            hit          <= 1'b0;
            miss         <= 1'b0;
            repeat_guess <= 1'b0;
            case (cur)
                IDLE, DONE: begin
                    if (start) begin
                        word_out    <= '0;
                        word_len    <= '0;
                        reveal_mask <= '0;
                        misses      <= '0;
                        guessed     <= '0;
                        p2_won      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_wr) begin
                        for (int k = 0; k < MAX_LEN; k++) begin
                            if (word_len == LEN_W'(k)) word_out[k*CHAR_W +: CHAR_W] <= char_in;
                        end
                        word_len <= word_len + 1'b1;
                    end
                end
                GUESS: if (guess_take) guess_q <= char_in;
                CHECK: begin
                    reveal_mask <= new_mask;
                    misses      <= new_misses;
                    if (is_repeat) begin
                        repeat_guess <= 1'b1;
                    end else begin
                        guessed[guess_q] <= 1'b1;
                        if (match != '0) hit  <= 1'b1;
                        else             miss <= 1'b1;
                    end
                end
                WIN: begin
                    p2_won <= 1'b1;
                    if (p2_score != '1) p2_score <= p2_score + 1'b1;
                end
                LOSE: begin
                    p2_won <= 1'b0;
                    if (p1_score != '1) p1_score <= p1_score + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state      = cur;
    assign round_over = (cur == DONE);

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Directed plus randomized checks of hangman_round_ctrl against a word/set level
// model of a round; inputs change and outputs are sampled on the falling edge.
module tb_hangman_round_ctrl;
    import hangman_pkg::*;

    localparam int MAX_LEN    = 8;
    localparam int CHAR_W     = 5;
    localparam int MAX_MISSES = 9;
    localparam int TIME_LIMIT = 3;
    localparam int SCORE_W    = 7;
    localparam int SCORE_MAX  = 127;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0, char_valid = 1'b0, word_done = 1'b0, tick = 1'b0;
    logic [4:0]  char_in = '0;
    logic [2:0]  state;
    logic [39:0] word_out;
    logic [3:0]  word_len;
    logic [7:0]  reveal_mask;
    logic [3:0]  misses;
    logic [1:0]  time_left;
    logic        hit, miss, repeat_guess, round_over, p2_won;
    logic [6:0]  p1_score, p2_score;

    int errors = 0;
    int checks = 0;

    int     m_word[$];
    bit     m_guessed[32];
    int     m_mask, m_misses, m_tl, m_p1, m_p2, m_won;
    state_t m_state;

    hangman_round_ctrl #(
        .MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .MAX_MISSES(MAX_MISSES),
        .TIME_LIMIT(TIME_LIMIT), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .char_in(char_in),
        .char_valid(char_valid), .word_done(word_done), .tick(tick),
        .state(state), .word_out(word_out), .word_len(word_len),
        .reveal_mask(reveal_mask), .misses(misses), .time_left(time_left),
        .hit(hit), .miss(miss), .repeat_guess(repeat_guess),
        .round_over(round_over), .p2_won(p2_won),
        .p1_score(p1_score), .p2_score(p2_score)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic cv, input logic [4:0] c,
                                 input logic wd, input logic tk);
        start = s; char_valid = cv; char_in = c; word_done = wd; tick = tk;
        @(negedge clk);
        start = 1'b0; char_valid = 1'b0; char_in = '0; word_done = 1'b0; tick = 1'b0;
    endtask

    function automatic logic [63:0] model_word();
        logic [63:0] w = '0;
        foreach (m_word[k]) w[k*5 +: 5] = m_word[k][4:0];
        return w;
    endfunction

    task automatic model_reset();
        m_word.delete();
        foreach (m_guessed[k]) m_guessed[k] = 1'b0;
        m_mask = 0; m_misses = 0; m_tl = 0; m_p1 = 0; m_p2 = 0; m_won = 0;
        m_state = IDLE;
    endtask

    task automatic finish_round();
        applyStimulus(0, 0, 0, 0, 0);
        if (m_state == WIN) begin
            m_p2 = (m_p2 < SCORE_MAX) ? m_p2 + 1 : SCORE_MAX; m_won = 1;
        end else begin
            m_p1 = (m_p1 < SCORE_MAX) ? m_p1 + 1 : SCORE_MAX; m_won = 0;
        end
        m_state = DONE;
        checkOutput("done_state", state, m_state);
        checkOutput("round_over", round_over, 1);
        checkOutput("p2_won", p2_won, m_won);
        checkOutput("p1_score", p1_score, m_p1);
        checkOutput("p2_score", p2_score, m_p2);
    endtask

    task automatic start_round();
        applyStimulus(1, 0, 0, 0, 0);
        m_word.delete();
        foreach (m_guessed[k]) m_guessed[k] = 1'b0;
        m_mask = 0; m_misses = 0; m_won = 0; m_state = LOAD;
        checkOutput("start_state", state, m_state);
        checkOutput("start_len", word_len, 0);
        checkOutput("start_mask", reveal_mask, 0);
        checkOutput("start_misses", misses, 0);
        checkOutput("start_round_over", round_over, 0);
    endtask

    task automatic load_step(input logic cv, input int c, input logic wd);
        applyStimulus(0, cv, c[4:0], wd, 0);
        if (cv && c != 0 && m_word.size() < MAX_LEN) m_word.push_back(c);
        if (wd && m_word.size() > 0) begin
            m_state = GUESS; m_tl = TIME_LIMIT;
        end
        checkOutput("load_len", word_len, m_word.size());
        checkOutput("load_word", word_out, model_word());
        checkOutput("load_state", state, m_state);
        if (m_state == GUESS) checkOutput("load_time", time_left, m_tl);
    endtask

    task automatic send_tick();
        applyStimulus(0, 0, 0, 0, 1);
        m_tl--;
        if (m_tl == 0) m_state = LOSE;
        checkOutput("tick_time", time_left, m_tl);
        checkOutput("tick_state", state, m_state);
        if (m_state == LOSE) finish_round();
    endtask

    task automatic make_guess(input int c, input logic tk);
        bit rep;
        int hp, full, exp_hit, exp_miss;
        applyStimulus(0, 1, c[4:0], 0, tk);
        if (c == 0) begin
            if (tk) begin
                m_tl--;
                if (m_tl == 0) m_state = LOSE;
            end
            checkOutput("nullguess_state", state, m_state);
            checkOutput("nullguess_time", time_left, m_tl);
            if (m_state == LOSE) finish_round();
            return;
        end
        checkOutput("guess_state", state, CHECK);
        applyStimulus(0, 0, 0, 0, 0);
        rep = m_guessed[c];
        hp = 0;
        foreach (m_word[k]) if (m_word[k] == c) hp |= (1 << k);
        exp_hit = 0; exp_miss = 0;
        if (!rep) begin
            m_guessed[c] = 1'b1;
            m_tl = TIME_LIMIT;
            if (hp != 0) begin m_mask |= hp; exp_hit = 1; end
            else begin m_misses++; exp_miss = 1; end
        end
        full = (1 << m_word.size()) - 1;
        if (m_mask == full)              m_state = WIN;
        else if (m_misses == MAX_MISSES) m_state = LOSE;
        else                             m_state = GUESS;
        checkOutput("hit", hit, exp_hit);
        checkOutput("miss", miss, exp_miss);
        checkOutput("repeat", repeat_guess, rep);
        checkOutput("mask", reveal_mask, m_mask);
        checkOutput("misses", misses, m_misses);
        checkOutput("check_state", state, m_state);
        checkOutput("check_time", time_left, m_tl);
        if (m_state == WIN || m_state == LOSE) finish_round();
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_state"}, state, IDLE);
        checkOutput({tag, "_word"}, word_out, 0);
        checkOutput({tag, "_len"}, word_len, 0);
        checkOutput({tag, "_mask"}, reveal_mask, 0);
        checkOutput({tag, "_misses"}, misses, 0);
        checkOutput({tag, "_time"}, time_left, 0);
        checkOutput({tag, "_pulses"}, {hit, miss, repeat_guess}, 0);
        checkOutput({tag, "_over_won"}, {round_over, p2_won}, 0);
        checkOutput({tag, "_scores"}, {p1_score, p2_score}, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        model_reset();
        #1 resetn = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;

        // Win on "CAB", with empty word_done and a null character ignored first
        start_round();
        load_step(0, 0, 1);
        load_step(1, 0, 0);
        load_step(1, 3, 0);
        load_step(1, 1, 0);
        load_step(1, 2, 0);
        load_step(0, 0, 1);
        make_guess(1, 0);
        make_guess(2, 0);
        make_guess(3, 0);

        // Lose after nine distinct misses
        start_round();
        load_step(1, 1, 0);
        load_step(0, 0, 1);
        for (int g = 2; g <= 10; g++) make_guess(g, 0);

        // Repeated guess neither misses nor reloads
        start_round();
        load_step(1, 1, 0);
        load_step(1, 1, 0);
        load_step(0, 0, 1);
        make_guess(5, 0);
        make_guess(5, 0);
        make_guess(1, 0);

        // Timeout, entering the word with char and word_done together
        start_round();
        load_step(1, 4, 1);
        send_tick();
        send_tick();
        send_tick();

        // Guess beats the expiring tick and reloads the timer
        start_round();
        load_step(1, 7, 0);
        load_step(1, 8, 0);
        load_step(0, 0, 1);
        send_tick();
        send_tick();
        make_guess(7, 1);
        make_guess(8, 0);

        // Randomized rounds
        for (int r = 0; r < 20; r++) begin
            int guard;
            start_round();
            for (int k = $urandom_range(1, 8); k > 0; k--) load_step(1, $urandom_range(1, 6), 0);
            if ($urandom_range(0, 3) == 0) load_step(1, $urandom_range(0, 6), 1);
            else                           load_step(0, 0, 1);
            guard = 0;
            while (m_state == GUESS && guard < 80) begin
                guard++;
                if ($urandom_range(0, 3) == 0) send_tick();
                else make_guess($urandom_range(0, 9), $urandom_range(0, 4) == 0);
            end
            checkOutput("rand_round_over", round_over, 1);
        end

        // Overflowing word, then reset in the middle of guessing
        start_round();
        for (int k = 1; k <= 8; k++) load_step(1, k, 0);
        load_step(1, 9, 1);
        checkOutput("overflow_len", word_len, 8);
        make_guess(3, 0);
        #2 resetn = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        resetn = 1'b1;
        @(negedge clk);

        // Saturate p2_score, then win once more
        for (int r = 0; r <= SCORE_MAX; r++) begin
            start_round();
            load_step(1, 1, 1);
            make_guess(1, 0);
        end
        checkOutput("p2_saturated", p2_score, SCORE_MAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
